ram_rr_arbiter: RTL
===================

// Module: ram_rr_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM (1-cycle registered read) between two requesters.
//   Typical requesters: req0 = neuron-update engine (membrane-potential read/modify/write),
//   req1 = host loader/readout.
//   Arbitration is round-robin, one access per cycle, with a bounded lock for atomic
//   read-modify-write sequences.
//   Read data is returned with a per-requester valid strobe, aligned to the RAM latency.
// PARAMETERS
//   ADDR_W    14  RAM address width
//   DATA_W    16  RAM data width
//   LOCK_MAX  4   maximum consecutive grants a locking requester may hold (>=2)
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   reset      in   1       synchronous, active-high
//   req0/req1  in   1       access request; held until gnt seen
//   we0/we1    in   1       1 = write, 0 = read
//   addr0/1    in   ADDR_W  access address
//   wdata0/1   in   DATA_W  write data
//   lock0/1    in   1       with req: keep priority for this requester's next request
//   gnt0/gnt1  out  1       combinational; request accepted this cycle
//   rvalid0/1  out  1       registered; read data valid for that requester
//   rdata      out  DATA_W  = ram_q; qualified by rvalid0/rvalid1
//   ram_addr   out  ADDR_W  to RAM address (combinational from winner)
//   ram_d      out  DATA_W  to RAM data in
//   ram_we     out  1       to RAM write enable
//   ram_q      in   DATA_W  RAM registered read data
// BEHAVIOUR
//   - Reset (sync, active-high):
//     - last=1, so req0 wins first contention.
//     - lock_owner=none, lock_cnt=0, rvalid0=rvalid1=0.
//     - While reset is high, gnt0=gnt1=0 and ram_we=0.
//   - Winner (cycle t, combinational):
//     1. If lock_owner=k, req_k=1 and lock_cnt<LOCK_MAX: winner=k.
//     2. Else if exactly one req: that requester wins.
//     3. Else if both req: winner = requester != last.
//     4. Else: no winner.
//   - Ports driven from the winner:
//     - gnt_winner=1.
//     - ram_addr/ram_d = winner's addr/wdata.
//     - ram_we = winner's we.
//   - No winner:
//     - ram_we=0.
//     - ram_addr/ram_d hold the req0 values (don't-care reads are harmless).
//   - At posedge ending t with a winner:
//     - last <= winner.
//     - If winner read: rvalid_winner <= 1, else rvalid_winner <= 0.
//     - The other rvalid <= 0.
//     - With no winner, both rvalid <= 0.
//   - Read latency: the RAM captures the address at the end of cycle t.
//     ram_q and rvalid are valid in cycle t+1. Pipelined: one read per cycle, back-to-back.
//   - Write: takes effect at the end of cycle t. A read of the same address in t+1 returns
//     the new data.
//   - Lock state:
//     - Granted with lock_k=1: lock_owner<=k, lock_cnt<=lock_cnt+1 (first lock grant -> 1).
//     - Granted with lock_k=0, or lock owner's req=0 in a cycle: lock_owner<=none,
//       lock_cnt<=0.
//     - lock_cnt reaches LOCK_MAX: lock is forcibly released; normal round-robin next cycle.
//       The other requester, if requesting, wins before the owner may lock again.
//     - lock from a non-winning requester is ignored.
//   - Fairness: with both requesting continuously and no lock, grants alternate 0,1,0,1.
//     Worst-case wait = LOCK_MAX cycles.
//   - Reset mid-operation: an in-flight read's rvalid is cleared on the next edge. No
//     stale rvalid appears after reset deasserts.
//   - A requester must keep req/we/addr/wdata stable until gnt. Changing them early is
//     illegal.
// TESTING
//   1. Reset, then req0 read addr 0x0010 (RAM preloaded 0x1234):
//      -> gnt0 in cycle 1; rvalid0=1, rdata=0x1234 in cycle 2; rvalid1=0 throughout.
//   2. req0 write 0x0020<=0xBEEF; next cycle req1 read 0x0020:
//      -> gnt0 then gnt1; rvalid1 with rdata=0xBEEF.
//   3. Both request reads every cycle for 6 cycles, no lock:
//      -> gnt sequence 0,1,0,1,0,1; rvalid follows, one cycle late.
//   4. LOCK_MAX=4; req0 with lock0=1 held, req1 held:
//      -> gnt0 x4, then gnt1, then gnt0 (locked again).
//   5. Read granted in cycle t; reset asserted in cycle t+1:
//      -> rvalid0=0 on that edge; after reset, req0+req1 simultaneous -> req0 wins.
//   6. No requests for 5 cycles:
//      -> ram_we=0, gnt=0, rvalid=0 every cycle.

Source files
------------

// File: rtl/ram_rr_arbiter_if.sv
// rtl/ram_rr_arbiter_if.sv - requester-side access bundle for ram_rr_arbiter
interface ram_rr_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-port round-robin arbiter for a single-port synchronous RAM
// with a bounded lock for atomic read-modify-write sequences.
module ram_rr_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  ram_rr_arbiter_if.slave   p0,
  ram_rr_arbiter_if.slave   p1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int                CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_MAX);

  logic             last;
  logic             lock_valid;
  logic             lock_id;
  logic [CNT_W-1:0] lock_cnt;
  logic             rvalid0_q;
  logic             rvalid1_q;

  logic             win;
  logic             win_id;
  logic             win_we;
  logic             win_lock;
  logic             owner_req;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    win       = 1'b0;
    win_id    = 1'b0;
    owner_req = lock_id ? p1.req : p0.req;
    if (!reset) begin
      if (lock_valid && owner_req && (lock_cnt < CNT_MAX)) begin
        win    = 1'b1;
        win_id = lock_id;
      end else if (p0.req && p1.req) begin
        win    = 1'b1;
        win_id = ~last;
      end else if (p0.req) begin
        win    = 1'b1;
        win_id = 1'b0;
      end else if (p1.req) begin
        win    = 1'b1;
        win_id = 1'b1;
      end
    end
  end

  assign win_we   = win_id ? p1.we   : p0.we;
  assign win_lock = win_id ? p1.lock : p0.lock;
  // A lock only accumulates when the same requester keeps it; a new owner starts at 1.
  assign cnt_next = ((lock_valid && (lock_id == win_id)) ? lock_cnt : '0) + CNT_W'(1);

  assign p0.gnt    = win && !win_id;
  assign p1.gnt    = win &&  win_id;
  assign ram_addr  = (win && win_id) ? p1.addr  : p0.addr;
  assign ram_d     = (win && win_id) ? p1.wdata : p0.wdata;
  assign ram_we    = win && win_we;

  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.rdata  = ram_q;
  assign p1.rdata  = ram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= 1'b1;
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
      lock_cnt   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= win && !win_id && !win_we;
      rvalid1_q <= win &&  win_id && !win_we;
      if (win) begin
        last <= win_id;
        // Releasing at the grant that exhausts the budget hands the next contention to the other side.
        if (win_lock && (cnt_next < CNT_MAX)) begin
          lock_valid <= 1'b1;
          lock_id    <= win_id;
          lock_cnt   <= cnt_next;
        end else begin
          lock_valid <= 1'b0;
          lock_cnt   <= '0;
        end
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end
endmodule
